// File: rtl/alu_dispatch.sv
// Issue side of the core<->alu interface: accepts instruction words, reads operands from a
// 32-entry register file, drives one alu op at a time and writes the result back.
module alu_dispatch #(
  parameter int              DATA_W  = 64,
  parameter int              INSTR_W = 32,
  parameter int              ALU_LAT = 1,
  parameter logic [7:0]      NOP_OP  = 8'h80
) (
  input  logic               c,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic               host_we,
  input  logic [4:0]         host_waddr,
  input  logic [DATA_W-1:0]  host_wdata,
  input  logic [4:0]         dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [INSTR_W-1:0] alu_instr,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               result_valid,
  output logic [4:0]         result_rd,
  output logic [DATA_W-1:0]  result_data,
  output logic [15:0]        retired
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [INSTR_W-1:0] NOP_WORD = {{(INSTR_W-8){1'b0}}, NOP_OP};

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         rd_q;
  logic [DATA_W-1:0]  regs [32];

  logic [7:0]         op;
  logic [4:0]         rd, rs1, rs2;
  logic               accept, is_nop;
  logic               unused_bits;

  assign op          = in_instr[31:24];
  assign rd          = in_instr[23:19];
  assign rs1         = in_instr[18:14];
  assign rs2         = in_instr[13:9];
  assign unused_bits = ^in_instr[8:0];

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign is_nop    = (op == NOP_OP);
  assign dbg_rdata = regs[dbg_raddr];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !is_nop) state_nxt = EXEC;
      EXEC:    if (cnt == CNT_W'(1)) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_q         <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_instr    <= NOP_WORD;
      result_valid <= 1'b0;
      result_rd    <= '0;
      result_data  <= '0;
      retired      <= '0;
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Operands come straight from the array, so a host write on this edge is not seen.
          if (accept && !is_nop) begin
            alu_a     <= regs[rs1];
            alu_b     <= regs[rs2];
            alu_instr <= {{(INSTR_W-8){1'b0}}, op};
            rd_q      <= rd;
            cnt       <= CNT_W'(ALU_LAT);
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          // Drop back to NOP as soon as the op leaves EXEC so the alu output holds.
          if (cnt == CNT_W'(1)) alu_instr <= NOP_WORD;
        end
        WB: begin
          result_valid <= 1'b1;
          result_rd    <= rd_q;
          result_data  <= alu_out;
          retired      <= retired + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Register file: r0 is never written, so it always reads zero.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && host_we && host_waddr != 5'd0)
        regs[host_waddr] <= host_wdata;
      if (state == WB && rd_q != 5'd0)
        regs[rd_q] <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a one-cycle behavioural alu (0x20 add, 0x21 sub).
module tb_alu_dispatch;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        host_we = 1'b0;
  logic [4:0]  host_waddr = '0;
  logic [63:0] host_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [63:0] dbg_rdata;
  logic [63:0] alu_a, alu_b;
  logic [31:0] alu_instr;
  logic [63:0] alu_out = '0;
  logic        result_valid;
  logic [4:0]  result_rd;
  logic [63:0] result_data;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_retired = '0;

  alu_dispatch #(.DATA_W(64), .INSTR_W(32), .ALU_LAT(1), .NOP_OP(8'h80)) dut (
    .c(c), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr), .alu_out(alu_out),
    .result_valid(result_valid), .result_rd(result_rd), .result_data(result_data),
    .retired(retired)
  );

  always #5 c = ~c;

  // Behavioural alu: samples on each posedge, unknown opcodes (and NOP) hold the output.
  always @(posedge c) begin
    if (alu_instr[7:0] == 8'h20)      alu_out <= alu_a + alu_b;
    else if (alu_instr[7:0] == 8'h21) alu_out <= alu_a - alu_b;
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 9'd0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] addr, input logic [63:0] data);
    @(negedge c);
    host_we = 1'b1; host_waddr = addr; host_wdata = data;
    @(posedge c); #1;
    host_we = 1'b0;
  endtask

  task automatic dbg_read(input logic [4:0] addr, output logic [63:0] data);
    dbg_raddr = addr;
    #1;
    data = dbg_rdata;
  endtask

  // Returns once the edge that accepts the current in_valid word has passed (plus #1).
  task automatic wait_accept(output bit ok, output longint t);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge c);
        t = longint'($time);
        #1;
        ok = 1'b1;
        return;
      end
      @(negedge c);
    end
  endtask

  task automatic issue(input logic [31:0] instr);
    bit ok;
    longint t;
    @(negedge c);
    in_valid = 1'b1; in_instr = instr;
    wait_accept(ok, t);
    in_valid = 1'b0;
    check("accept_timeout", 64'(ok), 64'd1);
  endtask

  // Number of edges after the accept edge until result_valid is seen; 0 on timeout.
  task automatic wait_result(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge c); #1;
      if (result_valid) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    logic [63:0] d;
    int          n;
    bit          ok0, ok1;
    longint      t0, t1;
    bit          seen;

    vecs[0] = '{"add_basic",   8'h20, 5'd3, 64'd5,               64'd7, 64'd12};
    vecs[1] = '{"add_rd0",     8'h20, 5'd0, 64'd5,               64'd7, 64'd12};
    vecs[2] = '{"add_wrap",    8'h20, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[3] = '{"sub_neg",     8'h21, 5'd7, 64'd3,               64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4] = '{"unknown_op",  8'h33, 5'd8, 64'd1,               64'd2, 64'hFFFF_FFFF_FFFF_FFFE};

    // Reset values
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_instr", 64'(alu_instr), 64'h80);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    @(negedge c); rst_n = 1'b1;

    // Table-driven single ops, rs1=r1, rs2=r2
    for (int v = 0; v < 5; v++) begin
      host_write(5'd1, vecs[v].a);
      host_write(5'd2, vecs[v].b);
      issue(mk(vecs[v].op, vecs[v].rd, 5'd1, 5'd2));
      check({vecs[v].name, "_alu_instr"}, 64'(alu_instr), 64'(vecs[v].op));
      wait_result(n);
      exp_retired++;
      check({vecs[v].name, "_latency"}, 64'(n), 64'd2);
      check({vecs[v].name, "_data"}, result_data, vecs[v].exp);
      check({vecs[v].name, "_rd"}, 64'(result_rd), 64'(vecs[v].rd));
      check({vecs[v].name, "_retired"}, 64'(retired), 64'(exp_retired));
      check({vecs[v].name, "_ready"}, 64'(in_ready), 64'd1);
      check({vecs[v].name, "_alu_nop"}, 64'(alu_instr), 64'h80);
      dbg_read(vecs[v].rd, d);
      check({vecs[v].name, "_dbg"}, d, (vecs[v].rd == 5'd0) ? 64'd0 : vecs[v].exp);
      @(posedge c); #1;
      check({vecs[v].name, "_pulse"}, 64'(result_valid), 64'd0);
    end

    // Back-to-back with in_valid held: r3=r1+r2, then r4=r3+r3
    host_write(5'd1, 64'd5);
    host_write(5'd2, 64'd7);
    @(negedge c);
    in_valid = 1'b1; in_instr = mk(8'h20, 5'd3, 5'd1, 5'd2);
    wait_accept(ok0, t0);
    in_instr = mk(8'h20, 5'd4, 5'd3, 5'd3);
    wait_accept(ok1, t1);
    in_valid = 1'b0;
    check("b2b_accepts", 64'(ok0 && ok1), 64'd1);
    check("b2b_spacing", 64'((t1 - t0) / 10), 64'd3);
    wait_result(n);
    exp_retired += 2;
    check("b2b_data", result_data, 64'd24);
    dbg_read(5'd4, d);
    check("b2b_dbg_r4", d, 64'd24);
    check("b2b_retired", 64'(retired), 64'(exp_retired));

    // NOP: no issue, no writeback, ready again next cycle
    issue(mk(8'h80, 5'd9, 5'd1, 5'd2));
    check("nop_ready", 64'(in_ready), 64'd1);
    check("nop_alu_instr", 64'(alu_instr), 64'h80);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge c); #1;
      if (result_valid) seen = 1'b1;
    end
    check("nop_no_result", 64'(seen), 64'd0);
    check("nop_retired", 64'(retired), 64'(exp_retired));

    // host_we during EXEC is ignored
    host_write(5'd6, 64'd1);
    issue(mk(8'h20, 5'd10, 5'd1, 5'd2));
    @(negedge c);
    host_we = 1'b1; host_waddr = 5'd6; host_wdata = 64'd9;
    @(posedge c); #1;
    host_we = 1'b0;
    wait_result(n);
    exp_retired++;
    dbg_read(5'd6, d);
    check("exec_hostwe_ignored", d, 64'd1);

    // host write and accept on the same edge: op sees the pre-write value
    @(negedge c);
    host_we = 1'b1; host_waddr = 5'd6; host_wdata = 64'd9;
    in_valid = 1'b1; in_instr = mk(8'h20, 5'd11, 5'd6, 5'd2);
    @(posedge c); #1;
    host_we = 1'b0; in_valid = 1'b0;
    wait_result(n);
    exp_retired++;
    check("same_edge_latency", 64'(n), 64'd2);
    check("same_edge_result", result_data, 64'd8);
    dbg_read(5'd6, d);
    check("same_edge_r6", d, 64'd9);
    check("same_edge_retired", 64'(retired), 64'(exp_retired));

    // Asynchronous reset in the middle of EXEC
    issue(mk(8'h20, 5'd12, 5'd1, 5'd2));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_instr", 64'(alu_instr), 64'h80);
    check("mid_rst_alu_b", alu_b, 64'd0);
    check("mid_rst_retired", 64'(retired), 64'd0);
    check("mid_rst_result_data", result_data, 64'd0);
    dbg_read(5'd3, d);
    check("mid_rst_regfile", d, 64'd0);
    @(negedge c); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge c); #1;
      if (result_valid) seen = 1'b1;
    end
    check("post_rst_no_result", 64'(seen), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    dbg_read(5'd12, d);
    check("post_rst_r12", d, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
